// File: rtl/alu_seq_if.sv
// Operand/request and result/flag bundle between the register-read stage and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Aluop;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             zero;
    logic             V;
    logic             SET;
    logic             dz;

    modport master (
        output start, A, B, Aluop,
        input  busy, done, r, co, zero, V, SET, dz
    );

    modport slave (
        input  start, A, B, Aluop,
        output busy, done, r, co, zero, V, SET, dz
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a multi-cycle unsigned modulo (restoring division); done pulses when r/flags update.
// Latency 1 cycle for and/or/xor/nor/slt/add/sub and mod-by-zero, WIDTH+1 for mod; start is dropped while busy.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_co;
    logic             r_zero;
    logic             r_v;
    logic             r_set;
    logic             r_dz;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_v_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_co;
    logic             w_v;
    logic             w_set;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_nxt;

    assign w_add   = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_sub   = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
    assign w_v_sub = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_sub[WIDTH-1] != bus.A[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_co  = 1'b0;
        w_v   = 1'b0;
        w_set = 1'b0;
        case (bus.Aluop)
            3'b000: w_res = bus.A & bus.B;
            3'b001: w_res = bus.A | bus.B;
            3'b010: w_res = bus.A ^ bus.B;
            3'b011: w_res = ~(bus.A | bus.B);
            3'b100: begin
                w_set = w_sub[WIDTH-1] ^ w_v_sub;
                w_res = {{(WIDTH-1){1'b0}}, w_set};
            end
            3'b101: begin
                w_res = w_add[WIDTH-1:0];
                w_co  = w_add[WIDTH];
                w_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_add[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b110: begin
                w_res = w_sub[WIDTH-1:0];
                w_co  = w_sub[WIDTH];
                w_v   = w_v_sub;
            end
            default: ;
        endcase
    end

    // Shifted partial remainder kept one bit wider so divisors with the MSB set still compare correctly.
    assign w_sh      = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial   = w_sh - {1'b0, r_dvs};
    assign w_rem_nxt = w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_co    <= 1'b0;
            r_zero  <= 1'b0;
            r_v     <= 1'b0;
            r_set   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.Aluop != 3'b111) begin
                            r_r    <= w_res;
                            r_zero <= (w_res == '0);
                            r_co   <= w_co;
                            r_v    <= w_v;
                            r_set  <= w_set;
                            r_dz   <= 1'b0;
                            r_done <= 1'b1;
                        end else if (bus.B == '0) begin
                            r_r    <= bus.A;
                            r_zero <= (bus.A == '0);
                            r_co   <= 1'b0;
                            r_v    <= 1'b0;
                            r_set  <= 1'b0;
                            r_dz   <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_dvd   <= bus.A;
                            r_dvs   <= bus.B;
                            r_rem   <= '0;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                            r_state <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last iteration publishes the remainder directly, giving done WIDTH+1 cycles after start.
                    if (r_cnt == CNT_W'(1)) begin
                        r_r     <= w_rem_nxt;
                        r_zero  <= (w_rem_nxt == '0);
                        r_co    <= 1'b0;
                        r_v     <= 1'b0;
                        r_set   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.r    = r_r;
    assign bus.co   = r_co;
    assign bus.zero = r_zero;
    assign bus.V    = r_v;
    assign bus.SET  = r_set;
    assign bus.dz   = r_dz;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model predictions, a negedge monitor pops them on done.
module tb_alu_seq;
    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] r;
        logic         co;
        logic         zero;
        logic         v;
        logic         set;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busy_start = 0;
    int   busy_end = -1;
    exp_t q[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic; k is the cycle in which start is presented.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        exp_t   e;
        longint sa, sb, s;
        logic [W:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op; e.r = '0; e.co = 0; e.v = 0; e.set = 0; e.dz = 0; e.cyc = k + 1;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: e.r = a ^ b;
            3'd3: e.r = ~(a | b);
            3'd4: begin e.set = (sa < sb); e.r[0] = e.set; end
            3'd5: begin
                wide = {1'b0, a} + {1'b0, b};
                e.r = wide[W-1:0]; e.co = wide[W];
                s = sa + sb; e.v = (s > SMAX) || (s < SMIN);
            end
            3'd6: begin
                e.r = a - b; e.co = (a >= b);
                s = sa - sb; e.v = (s > SMAX) || (s < SMIN);
            end
            default: begin
                if (b == '0) begin e.r = a; e.dz = 1; end
                else begin e.r = a % b; e.cyc = k + W + 1; end
            end
        endcase
        e.zero = (e.r == '0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.Aluop = op; bus.A = a; bus.B = b;
        if (cyc > busy_end) begin
            q.push_back(model(op, a, b, cyc));
            if (op == 3'd7 && b != '0) begin
                busy_start = cyc + 1;
                busy_end   = cyc + W;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        bus.start = 1'b0;
        while (cyc <= busy_end) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.busy !== ((cyc >= busy_start) && (cyc <= busy_end))) begin
                failures++;
                $display("FAIL busy cyc=%0d: got %b want %b", cyc, bus.busy, (cyc >= busy_start) && (cyc <= busy_end));
            end
            if (q.size() != 0 && q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missing_done op=%0d: no done by cyc=%0d, want at cyc=%0d", q[0].op, cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_done cyc=%0d: got done=1 r=%h want no done", cyc, bus.r);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.r !== e.r || bus.co !== e.co || bus.zero !== e.zero || bus.V !== e.v ||
                        bus.SET !== e.set || bus.dz !== e.dz || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL result op=%0d: got r=%h co=%b z=%b V=%b SET=%b dz=%b cyc=%0d, want r=%h co=%b z=%b V=%b SET=%b dz=%b cyc=%0d",
                                 e.op, bus.r, bus.co, bus.zero, bus.V, bus.SET, bus.dz, cyc,
                                 e.r, e.co, e.zero, e.v, e.set, e.dz, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Aluop = '0;
        idle(3);
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.r !== '0 || bus.co !== 0 || bus.zero !== 0 ||
            bus.V !== 0 || bus.SET !== 0 || bus.dz !== 0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h co=%b z=%b V=%b SET=%b dz=%b, want all 0",
                     bus.busy, bus.done, bus.r, bus.co, bus.zero, bus.V, bus.SET, bus.dz);
        end
        rst_n = 1'b1;
        idle(2);

        // Directed cases from the block's intended behaviour.
        issue(3'd0, 32'h0000_07FF, 32'h0000_FC7B); idle(1);
        issue(3'd5, 32'h7FFF_FFFF, 32'h0000_0001); idle(1);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0000_0001); idle(1);
        issue(3'd6, 32'd25, 32'd8);
        issue(3'd4, 32'd3, 32'd15);
        issue(3'd4, 32'hFFFF_FFFF, 32'd1);
        issue(3'd4, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'd1);
        idle(2);

        issue(3'd7, 32'd31, 32'd4);
        idle(4);
        issue(3'd7, 32'd100, 32'd7);
        wait_idle();
        idle(2);
        issue(3'd7, 32'd31, 32'd0);
        issue(3'd5, 32'd1, 32'd1);
        idle(2);

        issue(3'd7, 32'd1000, 32'd7);
        idle(9);
        rst_n = 1'b0;
        q.delete();
        busy_end = -1;
        #1;
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.r !== '0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b r=%h, want busy=0 done=0 r=0", bus.busy, bus.done, bus.r);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        issue(3'd7, 32'd1000, 32'd7);
        wait_idle();
        idle(2);

        // Back-to-back single-cycle ops with start held high.
        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 6)), $urandom, $urandom);
        end
        idle(2);

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = a;
                3: b = {1'b1, 31'($urandom)};
                default: begin a = {1'b1, 31'($urandom_range(0, 3))}; b = $urandom_range(0, 3); end
            endcase
            issue(op, a, b);
            idle($urandom_range(0, 2));
        end

        wait_idle();
        idle(4);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: got %0d outstanding results, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU: same 3-bit Aluop encoding and same flag outputs (co, zero, V, SET).
- Adds a start/busy/done handshake, registered results, a multi-cycle unsigned modulo unit (restoring division) and a divide-by-zero flag.
- Sits between the register file read stage and write-back. The control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the division iteration counter; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  operation request; sampled on rising edge; accepted only when busy=0.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- Aluop  input  3  000 and, 001 or, 010 xor, 011 nor, 100 slt, 101 add, 110 sub, 111 mod.
- busy  output  1  high while a modulo iteration is in progress.
- done  output  1  one-cycle pulse: r and flags updated this cycle.
- r  output  WIDTH  registered result; holds until the next done.
- co  output  1  carry-out (add), no-borrow (sub).
- zero  output  1  r == 0.
- V  output  1  signed overflow (add/sub).
- SET  output  1  signed A < B (slt only).
- dz  output  1  modulo with B == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, r=0, co=0, zero=0, V=0, SET=0, dz=0; counter and operand registers cleared.
- Reset asserted mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, DIV.
- IDLE, start=1, Aluop!=111: result computed from A/B and registered at the same edge; done=1 in the following cycle (latency 1). Stays IDLE.
- IDLE, start=1, Aluop=111, B!=0: latch A and B; remainder register=0, counter=WIDTH; busy=1; go to DIV.
- IDLE, start=1, Aluop=111, B==0: r=A, dz=1, co=V=SET=0; done next cycle; busy stays 0.
- DIV, each cycle: rem = {rem[WIDTH-2:0], quo_msb}. If rem >= B, subtract B. Shift the dividend left. Decrement the counter.
- DIV, when the counter reaches 0: r=remainder, busy=0, done=1, return to IDLE. Latency from the start edge to done is WIDTH+1 cycles.
- start while busy=1 is ignored; no queueing.
- Back-to-back single-cycle ops: start held high every cycle gives done every cycle, each for the previous cycle's operands.
- add: {co,r} = A+B (WIDTH+1 bits). V = (A[msb]==B[msb]) && (r[msb]!=A[msb]).
- sub: {co,r} = A+~B+1. co=1 iff A >= B unsigned. V = (A[msb]!=B[msb]) && (r[msb]!=A[msb]).
- slt: SET = (A-B)[msb] XOR V_sub, i.e. correct signed compare including overflow. r = {(WIDTH-1)'b0, SET}. co=V=0.
- Logic ops: bitwise on full WIDTH; co=V=SET=0.
- zero is registered as (r==0) for every op, including mod.
- dz=0 for every op except mod with B==0.
- SET=0 for every op except slt.
- done is low in every cycle not listed above. All outputs hold their values between done pulses.

Test Plan:
- and: A=0x000007FF, B=0x0000FC7B, Aluop=000, start 1 cycle -> next cycle done=1, r=0x0000047B, zero=0, co=V=SET=0.
- add: 0x7FFFFFFF+0x00000001 -> r=0x80000000, V=1, co=0. Then 0xFFFFFFFF+1 -> r=0, co=1, zero=1, V=0. Both with latency 1.
- sub/slt: 25-8 -> r=17, co=1, V=0. slt 3,15 -> r=1, SET=1. slt 0xFFFFFFFF,1 -> SET=1. slt 0x80000000,0x7FFFFFFF -> SET=1 (overflow-corrected).
- mod: A=31, B=4, Aluop=111 -> busy=1 for 32 cycles, done exactly 33 cycles after the start edge, r=3. A second start at cycle 5 (A=100, B=7) is ignored: r still 3, no extra done.
- mod by zero: A=31, B=0 -> busy never asserts, done next cycle, r=31, dz=1. A following add 1+1 -> r=2, dz=0.
- reset mid-op: start mod 1000%7, drop rst_n at cycle 10 -> busy, done and r go to 0 immediately. After release, mod 1000%7 -> r=6 after 33 cycles.
